// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator control path.
// Contents: FSM state encoding, ALU opcodes, pushbutton bit map,
// operator-index to opcode mapping and one-hot helpers.
package calc_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY_A = 3'd1,
    OP_WAIT = 3'd2,
    ENTRY_B = 3'd3,
    EXEC    = 3'd4,
    SHOW    = 3'd5
  } state_t;

  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_MUL = 3'd3;

  // Bit map of the combined pushbutton vector {clear, enter, op[2:0], dig[9:0]}
  localparam int unsigned NUM_DIG  = 10;
  localparam int unsigned NUM_OP   = 3;
  localparam int unsigned PB_OP0   = 10;
  localparam int unsigned PB_ENTER = 13;
  localparam int unsigned PB_CLEAR = 14;
  localparam int unsigned PB_W     = 15;

  // Operator button index (0=ADD, 1=SUB, 2=MUL) to ALU opcode
  function automatic logic [2:0] op_index_to_code(input logic [1:0] idx);
    case (idx)
      2'd0:    return OP_ADD;
      2'd1:    return OP_SUB;
      default: return OP_MUL;
    endcase
  endfunction

  function automatic logic is_onehot10(input logic [9:0] v);
    return (v != 10'd0) && ((v & (v - 10'd1)) == 10'd0);
  endfunction

  function automatic logic is_onehot3(input logic [2:0] v);
    return (v != 3'd0) && ((v & (v - 3'd1)) == 3'd0);
  endfunction

endpackage

// File: rtl/pb_edge_sync.sv
// Pushbutton synchronizer and rising-edge detector.
// Ports:
//   clk    in  1      rising-edge clock
//   rst    in  1      asynchronous active-high reset
//   pb     in  WIDTH  raw asynchronous button levels
//   rise_c out WIDTH  one-cycle high when a synchronized level goes 0->1 (combinational)
module pb_edge_sync #(
  parameter int unsigned WIDTH       = 15,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pb,
  output logic [WIDTH-1:0] rise_c
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;

  // Shift chain; prev_q holds the last synchronized level for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= pb;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_c = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/calc_sequencer.sv
// Central control FSM for the calculator datapath.
// Turns pushbutton edges into one-cycle control pulses for the operand
// buffers and ALU.
// Ports:
//   hwclk        in   1  system clock (rising edge)
//   reset        in   1  asynchronous active-high reset
//   pb_dig       in  10  raw digit buttons, bit i = digit i
//   pb_op        in   3  raw operator buttons [0]=ADD [1]=SUB [2]=MUL
//   pb_enter     in   1  raw enter/equals button
//   pb_clear     in   1  raw clear button
//   store_digit  out  1  pulse: shift digit into new-operand buffer
//   digit        out  4  digit value, valid with store_digit
//   enter        out  1  pulse: copy op1 -> op2
//   result_ready out  1  pulse: load ALU result into op1
//   clear        out  1  pulse: clear both operand buffers
//   opcode       out  3  latched ALU opcode
//   busy         out  1  high while the ALU result is pending
//   state_o      out  3  current FSM state
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned MAX_DIGITS  = 3,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ALU_LAT     = 1
) (
  input  logic       hwclk,
  input  logic       reset,
  input  logic [9:0] pb_dig,
  input  logic [2:0] pb_op,
  input  logic       pb_enter,
  input  logic       pb_clear,
  output logic       store_digit,
  output logic [3:0] digit,
  output logic       enter,
  output logic       result_ready,
  output logic       clear,
  output logic [2:0] opcode,
  output logic       busy,
  output logic [2:0] state_o
);

  localparam int unsigned CNT_W  = $clog2(MAX_DIGITS + 1);
  localparam int unsigned WAIT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  logic [PB_W-1:0]   rise_c;
  logic [NUM_DIG-1:0] dig_ev_c;
  logic [NUM_OP-1:0]  op_ev_c;
  logic              ev_clear_c;
  logic              ev_enter_c;
  logic              ev_op_c;
  logic              ev_dig_c;
  logic [3:0]        dig_idx_c;
  logic [1:0]        op_idx_c;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [WAIT_W-1:0] wait_cnt;

  pb_edge_sync #(
    .WIDTH      (PB_W),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (hwclk),
    .rst   (reset),
    .pb    ({pb_clear, pb_enter, pb_op, pb_dig}),
    .rise_c(rise_c)
  );

  // Reduce the edge vector to at most one event; multi-key digit or
  // operator groups are invalid and fall through to the next priority
  always_comb begin
    dig_ev_c   = rise_c[NUM_DIG-1:0];
    op_ev_c    = rise_c[PB_OP0 +: NUM_OP];
    ev_clear_c = rise_c[PB_CLEAR];
    ev_enter_c = !ev_clear_c && rise_c[PB_ENTER];
    ev_op_c    = !ev_clear_c && !rise_c[PB_ENTER] && is_onehot3(op_ev_c);
    ev_dig_c   = !ev_clear_c && !rise_c[PB_ENTER] && !is_onehot3(op_ev_c)
                 && is_onehot10(dig_ev_c);
    dig_idx_c  = 4'd0;
    for (int i = 0; i < int'(NUM_DIG); i++) begin
      if (dig_ev_c[i]) dig_idx_c = 4'(i);
    end
    op_idx_c = 2'd0;
    for (int i = 0; i < int'(NUM_OP); i++) begin
      if (op_ev_c[i]) op_idx_c = 2'(i);
    end
  end

  // Sequencer: state, digit count, EXEC wait counter and registered outputs
  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      wait_cnt     <= '0;
      store_digit  <= 1'b0;
      digit        <= 4'd0;
      enter        <= 1'b0;
      result_ready <= 1'b0;
      clear        <= 1'b0;
      opcode       <= OP_ADD;
      busy         <= 1'b0;
    end else begin
      store_digit  <= 1'b0;
      enter        <= 1'b0;
      result_ready <= 1'b0;
      clear        <= 1'b0;
      if (ev_clear_c) begin
        clear  <= 1'b1;
        cnt    <= '0;
        opcode <= OP_ADD;
        busy   <= 1'b0;
        state  <= IDLE;
      end else begin
        case (state)
          IDLE, SHOW: begin
            if (ev_dig_c) begin
              store_digit <= 1'b1;
              digit       <= dig_idx_c;
              cnt         <= CNT_W'(1);
              state       <= ENTRY_A;
            end else if (ev_op_c && state == SHOW) begin
              // previous result becomes the first operand
              opcode <= op_index_to_code(op_idx_c);
              enter  <= 1'b1;
              cnt    <= '0;
              state  <= OP_WAIT;
            end
          end
          ENTRY_A, ENTRY_B: begin
            if (ev_dig_c) begin
              if (cnt < CNT_W'(MAX_DIGITS)) begin
                store_digit <= 1'b1;
                digit       <= dig_idx_c;
                cnt         <= cnt + CNT_W'(1);
              end
            end else if (ev_op_c && state == ENTRY_A) begin
              opcode <= op_index_to_code(op_idx_c);
              enter  <= 1'b1;
              cnt    <= '0;
              state  <= OP_WAIT;
            end else if (ev_enter_c && state == ENTRY_B) begin
              busy     <= 1'b1;
              wait_cnt <= WAIT_W'(ALU_LAT - 1);
              state    <= EXEC;
            end
          end
          OP_WAIT: begin
            if (ev_dig_c) begin
              store_digit <= 1'b1;
              digit       <= dig_idx_c;
              cnt         <= CNT_W'(1);
              state       <= ENTRY_B;
            end else if (ev_op_c) begin
              opcode <= op_index_to_code(op_idx_c);
            end
          end
          EXEC: begin
            if (wait_cnt == '0) begin
              result_ready <= 1'b1;
              busy         <= 1'b0;
              state        <= SHOW;
            end else begin
              wait_cnt <= wait_cnt - WAIT_W'(1);
            end
          end
          default: begin
            cnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign state_o = state;

endmodule
